// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: pc_sel encoding and the
// default exception entry address.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops compare the predicted top against the actual target.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] check_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             miss
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign empty   = (count == '0);
  assign top     = empty ? '0 : stack[top_ptr];

  // Entry storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      miss   <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (count != CNT_W'(DEPTH)) begin
          count <= count + CNT_W'(1);
        end
      end else if (pop) begin
        if (empty) begin
          miss <= 1'b1;
        end else begin
          miss   <= (stack[top_ptr] != check_data);
          wr_ptr <= top_ptr;
          count  <= count - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with target mux, exception entry/EPC and a return-address
// stack. Define PC_ALIGN_CHECK_EN to trap misaligned JR targets as exceptions.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCWre,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] branch_off,
  input  logic [25:0]      jump_idx,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             link,
  input  logic             ret,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_miss,
  output logic             addr_err
);

  logic [WIDTH-1:0] next_pc;
  logic             misaligned;
  logic             exc_entry;
  logic             push;
  logic             pop;

  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel_e'(pc_sel))
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + (branch_off << 2);
      PC_JUMP:   next_pc = {pc_plus4[WIDTH-1:28], jump_idx, 2'b00};
      PC_JR:     next_pc = jr_target;
      default:   next_pc = pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = (pc_sel == PC_JR) && (jr_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A trapped JR behaves exactly like an exception: no RAS activity at all.
  assign exc_entry = exc | misaligned;
  assign push      = PCWre & ~exc_entry & (pc_sel == PC_JUMP) & link;
  assign pop       = PCWre & ~exc_entry & (pc_sel == PC_JR) & ret;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc  <= RESET_VECTOR;
      epc <= '0;
    end else if (PCWre) begin
      if (exc_entry) begin
        pc  <= EXC_VECTOR;
        epc <= pc;
      end else begin
        pc <= next_pc;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= PCWre & ~exc & misaligned;
    end
  end
`else
  assign addr_err = 1'b0;
`endif

  pc_ras #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus4),
    .check_data(jr_target),
    .top       (ras_top),
    .empty     (ras_empty),
    .miss      (ras_miss)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand-written RAS/exception
// sequences, and randomized traffic against a queue-based reference model.
module tb_pc_unit;

  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] EV    = 32'h80;

  logic          CLK = 1'b0;
  logic          RST;
  logic          PCWre;
  logic [1:0]    pc_sel;
  logic [W-1:0]  branch_off;
  logic [25:0]   jump_idx;
  logic [W-1:0]  jr_target;
  logic          link;
  logic          ret;
  logic          exc;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_plus4;
  logic [W-1:0]  epc;
  logic [W-1:0]  ras_top;
  logic          ras_empty;
  logic          ras_miss;
  logic          addr_err;

  always #5 CLK = ~CLK;

  pc_unit #(
    .WIDTH(W), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .pc_sel(pc_sel),
    .branch_off(branch_off), .jump_idx(jump_idx), .jr_target(jr_target),
    .link(link), .ret(ret), .exc(exc),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_miss(ras_miss), .addr_err(addr_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the RAS is just a queue, newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ras[$];
  logic        m_miss;
  logic        m_aerr;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] jr;
    logic        lnk;
    logic        rt;
    logic [31:0] exp_pc;
    logic [31:0] exp_top;
    logic        exp_empty;
    logic        exp_miss;
  } vec_t;

  vec_t vecs[13];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_step();
    logic [31:0] pc4;
    logic        misal;
    if (RST) begin
      m_pc   = RV;
      m_epc  = 32'h0;
      m_ras.delete();
      m_miss = 1'b0;
      m_aerr = 1'b0;
    end else begin
      m_miss = 1'b0;
      m_aerr = 1'b0;
      if (PCWre) begin
        pc4   = m_pc + 32'd4;
        misal = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        misal = (pc_sel == 2'd3) && (jr_target % 32'd4 != 32'd0);
`endif
        if (exc || misal) begin
          m_epc  = m_pc;
          m_pc   = EV;
          m_aerr = misal && !exc;
        end else begin
          case (pc_sel)
            2'd0: m_pc = pc4;
            2'd1: m_pc = pc4 + branch_off * 32'd4;
            2'd2: m_pc = (pc4 & 32'hF000_0000) + {4'h0, jump_idx, 2'b00};
            default: m_pc = jr_target;
          endcase
          if (pc_sel == 2'd2 && link) begin
            m_ras.push_back(pc4);
            if (m_ras.size() > DEPTH) m_ras.delete(0);
          end
          if (pc_sel == 2'd3 && ret) begin
            if (m_ras.size() == 0) m_miss = 1'b1;
            else begin
              if (m_ras[m_ras.size()-1] != jr_target) m_miss = 1'b1;
              m_ras.delete(m_ras.size()-1);
            end
          end
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic we, input logic [1:0] sel,
                                input logic [31:0] off, input logic [25:0] idx,
                                input logic [31:0] jr, input logic lnk, input logic rt,
                                input logic ex);
    RST = rst; PCWre = we; pc_sel = sel; branch_off = off; jump_idx = idx;
    jr_target = jr; link = lnk; ret = rt; exc = ex;
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " pc"},       pc,       m_pc);
    check_output({tag, " pc_plus4"}, pc_plus4, m_pc + 32'd4);
    check_output({tag, " epc"},      epc,      m_epc);
    check_output({tag, " ras_top"},  ras_top,  (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1]);
    check_output({tag, " ras_empty"}, {31'h0, ras_empty}, {31'h0, m_ras.size() == 0});
    check_output({tag, " ras_miss"}, {31'h0, ras_miss}, {31'h0, m_miss});
    check_output({tag, " addr_err"}, {31'h0, addr_err}, {31'h0, m_aerr});
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_top,
                              input logic e_empty, input logic e_miss);
    check_output({tag, " pc"},        pc, e_pc);
    check_output({tag, " ras_top"},   ras_top, e_top);
    check_output({tag, " ras_empty"}, {31'h0, ras_empty}, {31'h0, e_empty});
    check_output({tag, " ras_miss"},  {31'h0, ras_miss}, {31'h0, e_miss});
  endtask

  initial begin
    logic [31:0] rnd_jr;
    logic        r_rst;

    vecs[0]  = '{1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'hC, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'd3, 32'h0, 26'h0, 32'h100, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 2'd1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0, 32'hFC, 32'h0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 32'h0, 26'h0, 32'h1000_0000, 1'b0, 1'b0, 32'h1000_0000, 32'h0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 32'h0, 26'h40, 32'h0, 1'b0, 1'b0, 32'h1000_0100, 32'h0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 32'h0, 26'h0, 32'h200, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'd2, 32'h0, 26'h100, 32'h0, 1'b1, 1'b0, 32'h400, 32'h204, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 32'h0, 26'h0, 32'h204, 1'b0, 1'b1, 32'h204, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'd3, 32'h0, 26'h0, 32'h208, 1'b0, 1'b1, 32'h208, 32'h0, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h20C, 32'h0, 1'b1, 1'b0};

    // Reset state
    apply_stimulus(1'b1, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("reset pc", pc, 32'h0);
    check_output("reset pc_plus4", pc_plus4, 32'h4);
    check_output("reset epc", epc, 32'h0);
    check_output("reset ras_top", ras_top, 32'h0);
    check_output("reset ras_empty", {31'h0, ras_empty}, 32'h1);
    check_output("reset ras_miss", {31'h0, ras_miss}, 32'h0);
    check_output("reset addr_err", {31'h0, addr_err}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(1'b0, vecs[i].we, vecs[i].sel, vecs[i].off, vecs[i].idx, vecs[i].jr,
                     vecs[i].lnk, vecs[i].rt, 1'b0);
      expect_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_top,
                   vecs[i].exp_empty, vecs[i].exp_miss);
      check_output($sformatf("vec%0d epc", i), epc, 32'h0);
    end

    // Overflow: five linked jumps into a 4-deep stack lose the oldest return.
    apply_stimulus(1'b1, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b0, 1'b1, 2'd2, 32'h0, 26'(k * 32'h40), 32'h0, 1'b1, 1'b0, 1'b0);
      expect_state($sformatf("push%0d", k), k * 32'h100, (k - 1) * 32'h100 + 32'h4, 1'b0, 1'b0);
    end
    for (int k = 5; k >= 2; k--) begin
      apply_stimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, (k - 1) * 32'h100 + 32'h4, 1'b0, 1'b1, 1'b0);
      expect_state($sformatf("pop%0d", k), (k - 1) * 32'h100 + 32'h4,
                   (k >= 3) ? (k - 2) * 32'h100 + 32'h4 : 32'h0, (k == 2), 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h4, 1'b0, 1'b1, 1'b0);
    expect_state("pop_empty", 32'h4, 32'h0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 2'd3, 32'h0, 26'h0, 32'h4, 1'b0, 1'b1, 1'b0);
    expect_state("miss_clears_hold", 32'h4, 32'h0, 1'b1, 1'b0);

    // Exception together with JR+ret leaves the RAS intact.
    apply_stimulus(1'b1, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd2, 32'h0, 26'h3C, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_state("exc_setup_jal", 32'hF0, 32'h4, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h300, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h4, 1'b0, 1'b1, 1'b1);
    expect_state("exc_entry", 32'h80, 32'h4, 1'b0, 1'b0);
    check_output("exc_entry epc", epc, 32'h300);

    // Misaligned JR from pc=0x80 with a pending return of 0x4.
    apply_stimulus(1'b0, 1'b1, 2'd3, 32'h0, 26'h0, 32'h202, 1'b0, 1'b1, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    expect_state("misalign", 32'h80, 32'h4, 1'b0, 1'b0);
    check_output("misalign epc", epc, 32'h80);
    check_output("misalign addr_err", {31'h0, addr_err}, 32'h1);
`else
    expect_state("misalign", 32'h202, 32'h0, 1'b1, 1'b1);
    check_output("misalign epc", epc, 32'h300);
    check_output("misalign addr_err", {31'h0, addr_err}, 32'h0);
`endif
    apply_stimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("addr_err clears", {31'h0, addr_err}, 32'h0);
    check_output("miss clears", {31'h0, ras_miss}, 32'h0);

    // Reset mid-sequence wins over PCWre and discards the stack.
    apply_stimulus(1'b0, 1'b1, 2'd2, 32'h0, 26'h10, 32'h0, 1'b1, 1'b0, 1'b0);
    check_output("pre_reset ras_empty", {31'h0, ras_empty}, 32'h0);
    apply_stimulus(1'b1, 1'b1, 2'd2, 32'h0, 26'h10, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_state("mid_reset", 32'h0, 32'h0, 1'b1, 1'b0);
    check_output("mid_reset epc", epc, 32'h0);
    apply_stimulus(1'b0, 1'b1, 2'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_output("post_reset pc", pc, 32'h4);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) rnd_jr = m_ras[m_ras.size()-1];
      else begin
        rnd_jr = $urandom();
        if ($urandom_range(0, 7) != 0) rnd_jr[1:0] = 2'b00;
      end
      apply_stimulus(r_rst, ($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)),
                     $urandom(), 26'($urandom()), rnd_jr,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 11) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
